// File: rtl/goal_detector.sv
// goal_detector: detects ball entry into either gate mouth and sequences idle/play/hold/game-over.
// Ports: clk/reset (async, active-high); startOfFrame with ballX/ballY frame samples;
// start level; Max_goal_p1/p2 pulses; registered goal_p1/goal_p2/timer_done pulses
// and ball_hold/idle levels.
module goal_detector #(
  parameter int LEFT_LINE   = 40,
  parameter int RIGHT_LINE  = 600,
  parameter int GATE_TOP    = 180,
  parameter int GATE_BOTTOM = 300,
  parameter int HOLD_FRAMES = 120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic [10:0] ballX,
  input  logic [10:0] ballY,
  input  logic        start,
  input  logic        Max_goal_p1,
  input  logic        Max_goal_p2,
  output logic        goal_p1,
  output logic        goal_p2,
  output logic        timer_done,
  output logic        ball_hold,
  output logic        idle
);
  typedef enum logic [1:0] {IDLE, PLAY, HOLD, OVER} state_t;
  state_t state, state_n;
  logic [7:0] cnt, cnt_n;
  logic g1_n, g2_n, td_n;
  logic in_y, hit_r, hit_l, max_goal;
  assign in_y     = ballY >= 11'(GATE_TOP) && ballY <= 11'(GATE_BOTTOM);
  assign hit_r    = startOfFrame && ballX >= 11'(RIGHT_LINE) && in_y;
  assign hit_l    = startOfFrame && ballX <= 11'(LEFT_LINE) && in_y;
  assign max_goal = Max_goal_p1 || Max_goal_p2;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    g1_n    = 1'b0;
    g2_n    = 1'b0;
    td_n    = 1'b0;
    case (state)
      IDLE: if (start) state_n = PLAY;
      PLAY:
        if (max_goal) state_n = OVER;
        else if (hit_r || hit_l) begin
          state_n = HOLD;
          cnt_n   = 8'd0;
          g1_n    = hit_r;
          g2_n    = !hit_r;
        end
      HOLD:
        // Game over still releases the hold so the counters' goal flags clear.
        if (max_goal) begin
          state_n = OVER;
          td_n    = 1'b1;
          cnt_n   = 8'd0;
        end else if (startOfFrame) begin
          cnt_n = cnt + 8'd1;
          if (cnt_n == 8'(HOLD_FRAMES)) begin
            td_n    = 1'b1;
            cnt_n   = 8'd0;
            state_n = PLAY;
          end
        end
      OVER: if (!start) state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      goal_p1    <= 1'b0;
      goal_p2    <= 1'b0;
      timer_done <= 1'b0;
      ball_hold  <= 1'b1;
      idle       <= 1'b1;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      goal_p1    <= g1_n;
      goal_p2    <= g2_n;
      timer_done <= td_n;
      ball_hold  <= state_n != PLAY;
      idle       <= state_n == IDLE || state_n == OVER;
    end
  end
endmodule

// File: tb/tb_goal_detector.sv
// tb_goal_detector: table-driven scoreboard bench for goal_detector with a 3-frame hold.
module tb_goal_detector;
  logic clk = 1'b0, reset = 1'b1, sof = 1'b0, start = 1'b0, m1 = 1'b0, m2 = 1'b0;
  logic [10:0] bx = '0, by = '0;
  logic goal_p1, goal_p2, timer_done, ball_hold, idle;
  int n_vec = 0, n_err = 0;
  logic [4:0] q[$];

  typedef struct {
    logic sof;
    logic [10:0] x, y;
    logic st, m1, m2;
    logic [4:0] exp;
  } vec_t;
  vec_t v[30];

  goal_detector #(.HOLD_FRAMES(3)) dut (
    .clk(clk), .reset(reset), .startOfFrame(sof), .ballX(bx), .ballY(by),
    .start(start), .Max_goal_p1(m1), .Max_goal_p2(m2),
    .goal_p1(goal_p1), .goal_p2(goal_p2), .timer_done(timer_done),
    .ball_hold(ball_hold), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string name);
    logic [4:0] exp, got;
    exp = q.pop_front();
    got = {goal_p1, goal_p2, timer_done, ball_hold, idle};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got {g1,g2,td,hold,idle}=%b expected %b", name, got, exp);
    end
  endtask

  task automatic apply(input vec_t t, input string name);
    sof = t.sof; bx = t.x; by = t.y; start = t.st; m1 = t.m1; m2 = t.m2;
    q.push_back(t.exp);
    @(posedge clk);
    #1;
    check(name);
  endtask

  initial begin
    v[0]  = '{0, 0,   0,   0, 0, 0, 5'b00011};
    v[1]  = '{1, 610, 200, 0, 0, 0, 5'b00011};
    v[2]  = '{0, 0,   0,   1, 0, 0, 5'b00000};
    v[3]  = '{1, 610, 200, 0, 0, 0, 5'b10010};
    v[4]  = '{0, 610, 200, 0, 0, 0, 5'b00010};
    v[5]  = '{1, 610, 200, 0, 0, 0, 5'b00010};
    v[6]  = '{1, 610, 200, 1, 0, 0, 5'b00010};
    v[7]  = '{0, 610, 200, 0, 0, 0, 5'b00010};
    v[8]  = '{1, 610, 200, 0, 0, 0, 5'b00100};
    v[9]  = '{0, 300, 200, 0, 0, 0, 5'b00000};
    v[10] = '{1, 20,  179, 0, 0, 0, 5'b00000};
    v[11] = '{1, 20,  180, 0, 0, 0, 5'b01010};
    v[12] = '{1, 20,  180, 0, 0, 0, 5'b00010};
    v[13] = '{0, 300, 200, 0, 0, 1, 5'b00111};
    v[14] = '{0, 300, 200, 1, 0, 0, 5'b00011};
    v[15] = '{1, 610, 200, 1, 0, 0, 5'b00011};
    v[16] = '{0, 300, 200, 0, 0, 0, 5'b00011};
    v[17] = '{0, 300, 200, 1, 0, 0, 5'b00000};
    v[18] = '{0, 610, 200, 0, 0, 0, 5'b00000};
    v[19] = '{0, 20,  200, 0, 0, 0, 5'b00000};
    v[20] = '{1, 300, 200, 0, 0, 0, 5'b00000};
    v[21] = '{1, 599, 200, 0, 0, 0, 5'b00000};
    v[22] = '{1, 600, 300, 0, 0, 0, 5'b10010};
    v[23] = '{1, 300, 200, 0, 0, 0, 5'b00010};
    v[24] = '{1, 300, 200, 0, 0, 0, 5'b00010};
    v[25] = '{1, 300, 200, 0, 0, 0, 5'b00100};
    v[26] = '{1, 40,  301, 0, 0, 0, 5'b00000};
    v[27] = '{1, 41,  200, 0, 0, 0, 5'b00000};
    v[28] = '{0, 300, 200, 0, 1, 0, 5'b00011};
    v[29] = '{0, 300, 200, 0, 0, 0, 5'b00011};

    repeat (2) @(posedge clk);
    #1;
    q.push_back(5'b00011);
    check("reset_values");
    reset = 1'b0;
    for (int i = 0; i < 30; i++) apply(v[i], $sformatf("vec%0d", i));

    apply('{0, 0, 0, 1, 0, 0, 5'b00000}, "rst_seq_start");
    apply('{1, 610, 250, 0, 0, 0, 5'b10010}, "rst_seq_goal");
    apply('{1, 300, 200, 0, 0, 0, 5'b00010}, "rst_seq_frame1");
    apply('{1, 300, 200, 0, 0, 0, 5'b00010}, "rst_seq_frame2");
    sof = 1'b0;
    #2 reset = 1'b1;
    #1;
    q.push_back(5'b00011);
    check("async_reset_mid_hold");
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 5; i++) apply('{1, 610, 200, 0, 0, 0, 5'b00011}, $sformatf("post_reset%0d", i));
    apply('{0, 300, 200, 1, 0, 0, 5'b00000}, "post_reset_play");
    apply('{1, 300, 200, 0, 0, 0, 5'b00000}, "post_reset_no_td");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/goal_detector.md
GOAL_DETECTOR -- requirements
Module: goal_detector

Interface
REQ-001 Parameter LEFT_LINE, default 40: ball X (pixels) at or below which the ball is inside the left gate.
REQ-002 Parameter RIGHT_LINE, default 600: ball X at or above which the ball is inside the right gate.
REQ-003 Parameter GATE_TOP, default 180, and GATE_BOTTOM, default 300: inclusive Y window of both gate mouths.
REQ-004 Parameter HOLD_FRAMES, default 120: frames the ball is held after a goal (legal range 1..255).
REQ-005 clk  input  1  system clock; the block's only clock.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 startOfFrame  input  1  one-cycle pulse once per video frame.
REQ-008 ballX, ballY  input  11 each  unsigned ball top-left coordinates, stable while startOfFrame is high.
REQ-009 start  input  1  level; request to begin or restart a match.
REQ-010 Max_goal_p1, Max_goal_p2  input  1 each  pulses from the per-player goal counters.
REQ-011 goal_p1  output  1  one-cycle pulse; player 1 scored (right gate).
REQ-012 goal_p2  output  1  one-cycle pulse; player 2 scored (left gate).
REQ-013 timer_done  output  1  one-cycle pulse at the end of the post-goal hold.
REQ-014 ball_hold  output  1  level; ball logic freezes the ball at centre while high.
REQ-015 idle  output  1  level; game-over / waiting state; goal counters clear while high.

Function
REQ-016 The FSM SHALL have states IDLE, PLAY, HOLD, and OVER, and only these states.
REQ-017 The block SHALL sample ballX/ballY only on cycles with startOfFrame=1 and SHALL ignore them on all other cycles.
REQ-018 A right-gate hit SHALL be defined as ballX>=RIGHT_LINE and GATE_TOP<=ballY<=GATE_BOTTOM.
REQ-019 A left-gate hit SHALL be defined as ballX<=LEFT_LINE and the same Y window.
REQ-020 IDLE SHALL assert idle=1 and ball_hold=1, and SHALL move to PLAY on the first cycle with start=1.
REQ-021 In PLAY, a right-gate hit on a sampled frame SHALL register goal_p1=1 in the next cycle, and the FSM SHALL enter HOLD in that same next cycle.
REQ-022 In PLAY, a left-gate hit on a sampled frame SHALL register goal_p2=1 in the next cycle, and the FSM SHALL enter HOLD in that same next cycle.
REQ-023 If both hits are true on the same sample (misconfigured parameters), only goal_p1 SHALL fire.
REQ-024 At most one goal pulse SHALL be issued per entry into HOLD; further hits during HOLD SHALL be ignored.
REQ-025 HOLD SHALL assert ball_hold=1, clear an 8-bit frame counter on entry, and increment it on each startOfFrame.
REQ-026 When the frame counter reaches HOLD_FRAMES, the block SHALL pulse timer_done for exactly one cycle, clear the counter, and return to PLAY.
REQ-027 A Max_goal_p1 or Max_goal_p2 pulse SHALL move the FSM to OVER from PLAY or HOLD, with priority over every other transition.
REQ-028 If Max_goal arrives in HOLD, timer_done SHALL still pulse once on that same cycle so the counters' goal flags clear.
REQ-029 OVER SHALL assert idle=1 and ball_hold=1.
REQ-030 OVER SHALL move to IDLE when start=0, so that a level start held high cannot immediately restart the match.
REQ-031 start SHALL be ignored in PLAY and HOLD.
REQ-032 All outputs SHALL be registered, with no combinational path from input to output.

Reset
REQ-033 reset=1 SHALL immediately force state IDLE and frame counter 0.
REQ-034 reset=1 SHALL immediately force goal_p1=0, goal_p2=0, and timer_done=0.
REQ-035 reset=1 SHALL immediately force ball_hold=1 and idle=1.
REQ-036 A reset in any state, including mid-HOLD, SHALL discard the pending timer_done.
REQ-037 The first sample after reset release SHALL be evaluated only once the FSM is in PLAY.

Verification
REQ-038 Scenario: reset, then start=1 for 1 cycle, then a frame with ballX=610, ballY=200 -> goal_p1 one cycle after that startOfFrame, then HOLD with ball_hold=1.
REQ-039 Scenario: HOLD_FRAMES=3 after a goal, ball still in gate -> no second goal; timer_done exactly one cycle on the 3rd startOfFrame; back in PLAY.
REQ-040 Scenario: ballX=20, ballY=179 (outside the Y window) -> no goal; ballX=20, ballY=180 -> goal_p2.
REQ-041 Scenario: Max_goal_p2 pulse mid-HOLD -> timer_done pulse, then OVER with idle=1; start held at 1 -> stays in OVER; start=0 -> IDLE; start=1 -> PLAY.
REQ-042 Scenario: reset asserted two frames into HOLD -> outputs reach their reset values asynchronously, and no timer_done appears after release.
REQ-043 Scenario: ball coordinates changed between startOfFrame pulses into the gate and back out -> no goal.
